// File: rtl/piano_sequencer.sv
// -----------------------------------------------------------------------------
// piano_sequencer
//
// Small key-driven note sequencer. Live keys are priority-encoded into a note
// (lowest pressed key wins, note = key index + 1, 0 = silence) and can be
// played directly, recorded as (note, octave, duration) segments into a small
// buffer, played back from that buffer, or used as a "learn" target where the
// player must press the recorded notes in order to score.
//
// Parameters
//   NUM_KEYS  number of piano keys (note index must fit in 4 bits, <= 15)
//   DEPTH     recorded-segment buffer entries (power of two, >= 2)
//   TICK_DIV  clk cycles per duration tick
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   keys        piano keys, 1 = pressed
//   octave      live octave select
//   mode        100 free (rec=1 -> record), 010 playback, 001 learn,
//               anything else idle
//   rec         record arm, only meaningful with mode=100
//   note_out    0 = silence, 1..NUM_KEYS = note index
//   octave_out  octave accompanying note_out
//   led_out     one-hot key indication
//   score       learn-mode correct-hit count (saturates at 255)
//   busy        playback in progress
//   full        record buffer full
//
// Build option
//   SEQ_LOOP_EN  when defined, playback wraps from the last recorded entry back
//                to entry 0 forever; when undefined, playback stops after the
//                last entry with note_out=0 and busy=0 until PLAY is re-entered.
// -----------------------------------------------------------------------------
module piano_sequencer #(
    parameter int NUM_KEYS = 7,
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [1:0]          octave,
    input  logic [2:0]          mode,
    input  logic                rec,
    output logic [3:0]          note_out,
    output logic [1:0]          octave_out,
    output logic [NUM_KEYS-1:0] led_out,
    output logic [7:0]          score,
    output logic                busy,
    output logic                full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;                       // holds 0..DEPTH
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FREE  = 3'd1;
    localparam logic [2:0] S_REC   = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_LEARN = 3'd4;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [3:0]    live_note;       // encoded keys, one cycle late
    logic [1:0]    live_oct;
    logic [CW-1:0] count;           // valid entries in the buffer
    logic [AW-1:0] ptr;             // playback / learn position
    logic [TW-1:0] tick_cnt;
    logic [7:0]    dur_cnt;         // REC: open segment length; PLAY/LEARN: elapsed ticks
    logic [3:0]    seg_note;        // open record segment
    logic [1:0]    seg_oct;

    // Segment buffer: plain storage, contents are don't-care after reset.
    logic [3:0]    mem_note [DEPTH];
    logic [1:0]    mem_oct  [DEPTH];
    logic [7:0]    mem_dur  [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [3:0]    enc;
    logic          tick;
    logic [7:0]    dur_inc;
    logic          changing;
    logic          seg_change;
    logic          rec_exit;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] count_nxt;
    logic [3:0]    cur_note;
    logic [1:0]    cur_oct;
    logic [7:0]    cur_dur;
    logic [7:0]    need;
    logic          elapsed_ok;
    logic          ptr_last;
    logic [AW-1:0] ptr_adv;
    logic          press;

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [3:0] n);
        logic [NUM_KEYS-1:0] v;
        for (int i = 0; i < NUM_KEYS; i++)
            v[i] = (n == 4'(i + 1));
        return v;
    endfunction

    // Lowest-index pressed key wins: scan from the top so the last hit is lowest.
    always_comb begin
        enc = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (keys[i]) enc = 4'(i + 1);
    end

    always_comb begin
        case (mode)
            3'b100:  next_state = rec ? S_REC : S_FREE;
            3'b010:  next_state = S_PLAY;
            3'b001:  next_state = S_LEARN;
            default: next_state = S_IDLE;
        endcase
    end

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    // Duration including a tick that completes on this very edge.
    assign dur_inc  = (tick && dur_cnt != 8'hFF) ? dur_cnt + 8'd1 : dur_cnt;
    assign changing = (next_state != state);

    // The change is detected against the value the live registers are about
    // to take, so a segment ends exactly when the new note appears.
    assign seg_change = (state == S_REC) && !changing &&
                        ({enc, octave} != {seg_note, seg_oct});
    assign rec_exit   = (state == S_REC) && changing && (dur_inc != 8'd0) && !full;
    assign wr_en      = (seg_change && !full) || rec_exit;
    assign wr_addr    = count[AW-1:0];
    assign count_nxt  = wr_en ? count + CW'(1) : count;

    assign cur_note   = mem_note[ptr];
    assign cur_oct    = mem_oct[ptr];
    assign cur_dur    = mem_dur[ptr];
    // A zero-length entry still occupies one tick.
    assign need       = (cur_dur == 8'd0) ? 8'd1 : cur_dur;
    assign elapsed_ok = ({1'b0, dur_cnt} + 9'd1) >= {1'b0, need};
    assign ptr_last   = ((CW'(ptr) + CW'(1)) == count);
    assign ptr_adv    = ptr_last ? '0 : ptr + AW'(1);

    // New nonzero note appearing on the keys (press or slide to another key).
    assign press      = (enc != 4'd0) && (enc != live_note);

    // ------------------------------------------------------------------
    // Buffer write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_note[wr_addr] <= seg_note;
            mem_oct[wr_addr]  <= seg_oct;
            mem_dur[wr_addr]  <= dur_inc;
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            live_note <= '0;
            live_oct  <= '0;
            count     <= '0;
            ptr       <= '0;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            seg_note  <= '0;
            seg_oct   <= '0;
            score     <= '0;
            busy      <= 1'b0;
            full      <= 1'b0;
        end else begin
            state     <= next_state;
            live_note <= enc;
            live_oct  <= octave;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);

            if (wr_en) begin
                count <= count + CW'(1);
                if (count + CW'(1) == CW'(DEPTH))
                    full <= 1'b1;
            end

            if (changing) begin
                // Every state change restarts position and timing.
                ptr      <= '0;
                tick_cnt <= '0;
                dur_cnt  <= '0;
                busy     <= (next_state == S_PLAY) && (count_nxt != '0);
                case (next_state)
                    S_REC: begin
                        count    <= '0;
                        full     <= 1'b0;
                        seg_note <= enc;
                        seg_oct  <= octave;
                    end
                    S_LEARN: score <= '0;
                    default: ;
                endcase
            end else begin
                case (state)
                    S_REC: begin
                        if (seg_change) begin
                            seg_note <= enc;
                            seg_oct  <= octave;
                            dur_cnt  <= '0;
                            tick_cnt <= '0;
                        end else begin
                            dur_cnt  <= dur_inc;
                        end
                    end

                    S_PLAY: begin
                        if (busy && tick) begin
                            if (elapsed_ok) begin
                                dur_cnt <= '0;
                                if (ptr_last) begin
`ifdef SEQ_LOOP_EN
                                    ptr  <= '0;
`else
                                    busy <= 1'b0;
`endif
                                end else begin
                                    ptr <= ptr + AW'(1);
                                end
                            end else begin
                                dur_cnt <= dur_cnt + 8'd1;
                            end
                        end
                    end

                    S_LEARN: begin
                        if (count != '0) begin
                            if (cur_note == 4'd0) begin
                                // Rests cannot be played, so they time out.
                                if (tick) begin
                                    if (elapsed_ok) begin
                                        dur_cnt <= '0;
                                        ptr     <= ptr_adv;
                                    end else begin
                                        dur_cnt <= dur_cnt + 8'd1;
                                    end
                                end
                            end else if (press && enc == cur_note) begin
                                if (score != 8'hFF)
                                    score <= score + 8'd1;
                                ptr     <= ptr_adv;
                                dur_cnt <= '0;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (driven from registers only)
    // ------------------------------------------------------------------
    always_comb begin
        note_out   = '0;
        octave_out = '0;
        led_out    = '0;
        case (state)
            S_FREE, S_REC: begin
                note_out   = live_note;
                octave_out = live_oct;
                led_out    = onehot(live_note);
            end
            S_PLAY: begin
                if (busy) begin
                    note_out   = cur_note;
                    octave_out = cur_oct;
                    led_out    = onehot(cur_note);
                end
            end
            S_LEARN: begin
                note_out   = live_note;
                octave_out = live_oct;
                if (count != '0)
                    led_out = onehot(cur_note);
            end
            default: ;
        endcase
    end

endmodule
